hybrid_fp_post: RTL

- Downstream stage of the Hybrid rec/sqrt/isqrt datapath; turns Hybrid's fixed-point 2.(WL-2) result back into an IEEE-754 single-precision word.
- Captures the original FP32 operand and FUNCTION when the operand is issued to Hybrid. Delays the exponent/sign/special-case sideband to match Hybrid latency.
- Normalizes Hybrid's dout, computes the result exponent and substitutes special-case results.
- Emits a registered FP32 result with a valid strobe and exception flags.

---
 rtl/hybrid_fp_post.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hybrid_fp_post.sv
// Repacks Hybrid's 2.(WL-2) rec/sqrt/isqrt result into FP32 with exception flags.
// Latency: result registered LAT edges after the issue edge; no backpressure, CE freezes everything.
module hybrid_fp_post #(
    parameter int WL  = 25,
    parameter int LAT = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          CE,
    input  logic          in_valid,
    input  logic [1:0]    FUNCTION,
    input  logic [31:0]   in_fp,
    input  logic [WL-1:0] hyb_dout,
    output logic          out_valid,
    output logic [31:0]   fp_out,
    output logic          flag_invalid,
    output logic          flag_divzero,
    output logic          flag_underflow
);
    localparam logic [1:0]  FN_REC   = 2'b00;
    localparam logic [1:0]  FN_SQRT  = 2'b01;
    localparam logic [1:0]  FN_RSVD  = 2'b10;
    localparam logic [1:0]  FN_ISQRT = 2'b11;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] func;
        logic       sgn;
        cls_t       cls;
        logic [8:0] k;
    } sb_t;

    logic [7:0]        w_e;
    logic [22:0]       w_f;
    cls_t              w_cls;
    logic signed [8:0] w_ue;
    logic signed [8:0] w_half;
    logic signed [8:0] w_k;
    sb_t               w_sb_in;

    assign w_e = in_fp[30:23];
    assign w_f = in_fp[22:0];

    // Denormal operands are treated as zero.
    always_comb begin
        if (w_e == 8'd0)
            w_cls = CLS_ZERO;
        else if (w_e == 8'hFF)
            w_cls = (w_f == 23'd0) ? CLS_INF : CLS_NAN;
        else
            w_cls = CLS_NORM;
        w_ue   = $signed({1'b0, w_e}) - 9'sd127;
        w_half = w_ue >>> 1;
        case (FUNCTION)
            FN_REC:  w_k = -w_ue;
            FN_SQRT: w_k = w_half;
            default: w_k = -w_half;
        endcase
        w_sb_in = '{vld: in_valid, func: FUNCTION, sgn: in_fp[31], cls: w_cls, k: w_k};
    end

    sb_t r_sb [LAT];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < LAT; i++)
                r_sb[i] <= '0;
        end else if (CE) begin
            r_sb[0] <= w_sb_in;
            for (int i = 1; i < LAT; i++)
                r_sb[i] <= r_sb[i-1];
        end
    end

    sb_t                w_t;
    logic               w_hi;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp;
    logic               w_uf;
    logic [30:0]        w_mag;
    logic [31:0]        w_fp;
    logic               w_inv;
    logic               w_dz;
    logic               w_ufl;

    assign w_t = r_sb[LAT-1];

    // Hybrid output lies in [0.5,2); one leading-bit test normalises it.
    always_comb begin
        w_hi   = hyb_dout[WL-2];
        w_frac = w_hi ? hyb_dout[WL-3 -: 23] : {hyb_dout[WL-4 -: 22], 1'b0};
        w_exp  = $signed({w_t.k[8], w_t.k}) + (w_hi ? 10'sd127 : 10'sd126);
        w_uf   = (w_exp <= 10'sd0);
        w_mag  = w_uf ? 31'd0 : {w_exp[7:0], w_frac};

        w_fp  = QNAN;
        w_inv = 1'b0;
        w_dz  = 1'b0;
        w_ufl = 1'b0;
        case (w_t.func)
            FN_REC: begin
                case (w_t.cls)
                    CLS_ZERO: begin
                        w_fp = {w_t.sgn, POS_INF[30:0]};
                        w_dz = 1'b1;
                    end
                    CLS_INF:  w_fp = {w_t.sgn, 31'd0};
                    CLS_NAN:  w_fp = QNAN;
                    CLS_NORM: begin
                        w_fp  = {w_t.sgn, w_mag};
                        w_ufl = w_uf;
                    end
                endcase
            end
            FN_SQRT, FN_ISQRT: begin
                if (w_t.cls == CLS_NAN) begin
                    w_fp = QNAN;
                end else if (w_t.cls == CLS_ZERO) begin
                    if (w_t.func == FN_SQRT) begin
                        w_fp = {w_t.sgn, 31'd0};
                    end else begin
                        w_fp = POS_INF;
                        w_dz = 1'b1;
                    end
                end else if (w_t.sgn) begin
                    w_fp  = QNAN;
                    w_inv = 1'b1;
                end else if (w_t.cls == CLS_INF) begin
                    w_fp = (w_t.func == FN_SQRT) ? POS_INF : 32'd0;
                end else begin
                    w_fp  = {1'b0, w_mag};
                    w_ufl = w_uf;
                end
            end
            FN_RSVD: begin
                w_fp  = QNAN;
                w_inv = 1'b1;
            end
        endcase
    end

    logic w_unused_dout;
    generate
        if (WL > 25) begin : g_wide
            assign w_unused_dout = hyb_dout[WL-1] ^ (^hyb_dout[WL-26:0]);
        end else begin : g_exact
            assign w_unused_dout = hyb_dout[WL-1];
        end
    endgenerate

    logic        r_vld;
    logic [31:0] r_fp;
    logic        r_inv;
    logic        r_dz;
    logic        r_uf;

    // fp_out keeps its last value across bubbles; flags are cleared.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_vld <= 1'b0;
            r_fp  <= 32'd0;
            r_inv <= 1'b0;
            r_dz  <= 1'b0;
            r_uf  <= 1'b0;
        end else if (CE) begin
            r_vld <= w_t.vld;
            if (w_t.vld) begin
                r_fp  <= w_fp;
                r_inv <= w_inv;
                r_dz  <= w_dz;
                r_uf  <= w_ufl;
            end else begin
                r_inv <= 1'b0;
                r_dz  <= 1'b0;
                r_uf  <= 1'b0;
            end
        end
    end

    assign out_valid      = r_vld;
    assign fp_out         = r_fp;
    assign flag_invalid   = r_inv;
    assign flag_divzero   = r_dz;
    assign flag_underflow = r_uf;

endmodule
